mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Data-memory bus controller sitting directly downstream of the MEM stage. It accepts the MEM stage's single-cycle memory request (address, byte select, write data, write enable), runs it as a multi-cycle req/ack transaction on the external data bus, and holds the pipeline with `stall_req` until the access completes. Load data returns to the MEM stage on `read_data_from_mem`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: bus cycles without ack before abort; used only with `MEM_BUS_TIMEOUT_EN`.
- `ERR_RDATA`, 32'h0000_0000: load data returned on timeout abort.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_en`  in  1  chip enable from the MEM stage.
- `mem_write_en`  in  1  1 = store.
- `mem_load`  in  1  1 = load. Decoded from the EX/MEM aluop.
- `mem_select`  in  4  byte lanes.
- `mem_write_addr`  in  32  byte address.
- `mem_write_data`  in  32  store data.
- `read_data_from_mem`  out  32  load data to the MEM stage.
- `stall_req`  out  1  pipeline hold request to the control unit.
- `bus_req`  out  1  transaction request.
- `bus_we`  out  1  write strobe.
- `bus_sel`  out  4  byte lanes.
- `bus_addr`  out  32  word address, low 2 bits forced to 0.
- `bus_wdata`  out  32  store data.
- `bus_ack`  in  1  slave completion.
- `bus_rdata`  in  32  slave read data, valid with `bus_ack`.
- `bus_err`  out  1  one-cycle pulse on timeout abort (0 without macro).

## Operation
- Access condition: `access = mem_en & (mem_write_en | mem_load)`. `mem_write_en` has priority if both are set.
- FSM states are IDLE, BUSY, DONE.
  - IDLE: on `access`, latch addr/sel/wdata/we into `bus_*` registers, set `bus_req` = 1, go to BUSY. Otherwise stay.
  - BUSY: on `bus_ack`, capture `bus_rdata` (loads only), clear `bus_req`, go to DONE. Otherwise hold all `bus_*` stable.
  - DONE: go to IDLE unconditionally. A request still on the inputs is not restarted.
- `stall_req` is combinational: 1 when (IDLE & `access`) or BUSY. It is 0 in DONE and in IDLE without an access.
- `read_data_from_mem` is the captured register. It holds its value until the next load completes. Stores do not modify it.
- `bus_ack` is ignored in IDLE and DONE.
- The pipeline holds the MEM inputs stable while `stall_req` = 1. The block does not re-check them in BUSY.

## Timing
- Reset values: state IDLE, `bus_req` 0, `bus_we` 0, `bus_sel` 0, `bus_addr` 0, `bus_wdata` 0, `read_data_from_mem` 0, `bus_err` 0, timeout counter 0. `stall_req` is 0 because the state is IDLE.
- Minimum access when `bus_ack` arrives in the first BUSY cycle:
  - cycle 0 IDLE, stall;
  - cycle 1 BUSY, stall;
  - cycle 2 DONE, the MEM stage consumes the data, stall = 0.
  - This is 2 stall cycles.
- With N wait cycles in BUSY there are 2+N stall cycles.
- Back-to-back accesses: after DONE the next access starts from IDLE with no extra bubble.
- Reset asserted mid-BUSY drops `bus_req` asynchronously and returns the FSM to IDLE. The slave must tolerate request withdrawal.

## Configuration
- Macro `MEM_BUS_TIMEOUT_EN`.
  - Defined: an 8-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle without ack.
    - When it reaches `TIMEOUT_CYCLES`, the FSM clears `bus_req` and goes to DONE.
    - On a load, `read_data_from_mem` = `ERR_RDATA`.
    - `bus_err` pulses for 1 cycle, aligned with DONE.
    - An ack in the same cycle as the timeout wins.
  - Undefined: no counter. BUSY waits indefinitely, and `bus_err` is tied to 0.

## Structure
- Shared package `mem_bus_pkg` holds:
  - the FSM state enum (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2);
  - the default `TIMEOUT_CYCLES`;
  - the word-align mask 32'hFFFF_FFFC.
- Optional sub-module `mem_bus_watchdog` holds the timeout counter and compare. It is instantiated only under `MEM_BUS_TIMEOUT_EN`.

## Test plan
- Load, ack after 0 waits: addr 32'h0000_0106, sel 4'hF, `bus_rdata` 32'hCAFE_F00D.
  - `bus_addr` = 32'h0000_0104.
  - `stall_req` is high for 2 cycles.
  - `read_data_from_mem` = 32'hCAFE_F00D in DONE.
- Store, ack after 3 waits: addr 32'h40, data 32'h1234_5678, sel 4'b0011.
  - `bus_we` = 1 and `bus_sel` = 4'b0011, held stable for 4 BUSY cycles.
  - 5 stall cycles.
  - `read_data_from_mem` unchanged.
- Two back-to-back loads, 0 waits: stall pattern 1,1,0,1,1,0 and no duplicate `bus_req` for the first load.
- `mem_en` = 1 with neither load nor store: `stall_req` stays 0 and `bus_req` stays 0.
- `rst` pulsed during BUSY: `bus_req` falls in the same cycle and the state is IDLE.
  - A late `bus_ack` after reset is ignored and `read_data_from_mem` = 0.
- `MEM_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4, no ack on a load:
  - abort after 4 BUSY cycles;
  - `bus_err` is a single pulse;
  - data = `ERR_RDATA`;
  - the pipeline resumes.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus controller: FSM state encoding,
// default timeout and the word-alignment mask applied to bus addresses.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          DEF_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] WORD_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_bus_watchdog.sv
// Bus timeout watchdog: counts BUSY cycles without ack and flags the cycle
// in which the TIMEOUT_CYCLES-th unanswered BUSY cycle is reached.
// Only instantiated when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_timeout
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_cnt;

  // Counter restarts on BUSY entry and advances once per unanswered BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_cnt <= '0;
    else if (i_clr)           r_cnt <= '0;
    else if (i_busy && !i_ack) r_cnt <= r_cnt + 1'b1;
  end

  // r_cnt holds the number of earlier BUSY cycles, so this is the last one allowed.
  assign o_timeout = i_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller behind the MEM stage. Turns a single-cycle MEM
// request into a req/ack bus transaction and stalls the pipeline until done.
// Optional feature macro: MEM_BUS_TIMEOUT_EN (bus timeout abort + bus_err).
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_write_en,
  input  logic        mem_load,
  input  logic [3:0]  mem_select,
  input  logic [31:0] mem_write_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] read_data_from_mem,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  state_t      r_state, w_next;
  logic        w_access, w_timeout, w_start;
  logic        r_bus_req, r_bus_we, r_bus_err;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;

  assign w_access = mem_en & (mem_write_en | mem_load);
  assign w_start  = (r_state == IDLE) & w_access;

`ifdef MEM_BUS_TIMEOUT_EN
  mem_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_start),
    .i_busy    (r_state == BUSY),
    .i_ack     (bus_ack),
    .o_timeout (w_timeout)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and pipeline stall; ack takes priority over timeout.
  always_comb begin
    w_next    = r_state;
    stall_req = 1'b0;
    case (r_state)
      IDLE: if (w_access) begin
        stall_req = 1'b1;
        w_next    = BUSY;
      end
      BUSY: begin
        stall_req = 1'b1;
        if (bus_ack || w_timeout) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus request latch, load-data capture and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      if (w_start) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= mem_write_en;
        r_bus_sel   <= mem_select;
        r_bus_addr  <= mem_write_addr & WORD_ALIGN_MASK;
        r_bus_wdata <= mem_write_data;
      end else if (r_state == BUSY) begin
        if (bus_ack) begin
          r_bus_req <= 1'b0;
          if (!r_bus_we) r_rdata <= bus_rdata;
        end else if (w_timeout) begin
          r_bus_req <= 1'b0;
          r_bus_err <= 1'b1;
          if (!r_bus_we) r_rdata <= ERR_RDATA;
        end
      end
    end
  end

  assign bus_req            = r_bus_req;
  assign bus_we             = r_bus_we;
  assign bus_sel            = r_bus_sel;
  assign bus_addr           = r_bus_addr;
  assign bus_wdata          = r_bus_wdata;
  assign read_data_from_mem = r_rdata;
  assign bus_err            = r_bus_err;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl. Expected values are hand-derived.
// Build with MEM_BUS_TIMEOUT_EN defined to exercise the timeout abort.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_write_en, mem_load;
  logic [3:0]  mem_select;
  logic [31:0] mem_write_addr, mem_write_data;
  logic [31:0] read_data_from_mem;
  logic        stall_req, bus_req, bus_we, bus_ack, bus_err;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int st, st2;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_en             (mem_en),
    .mem_write_en       (mem_write_en),
    .mem_load           (mem_load),
    .mem_select         (mem_select),
    .mem_write_addr     (mem_write_addr),
    .mem_write_data     (mem_write_data),
    .read_data_from_mem (read_data_from_mem),
    .stall_req          (stall_req),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_sel            (bus_sel),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_ack            (bus_ack),
    .bus_rdata          (bus_rdata),
    .bus_err            (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drop_in();
    mem_en = 1'b0; mem_write_en = 1'b0; mem_load = 1'b0;
  endtask

  // Runs one access from IDLE; acks after 'waits' BUSY cycles. Returns in DONE.
  task automatic xact(input logic we, input logic ld, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] sel,
                      input int waits, input logic [31:0] rd, output int stalls);
    int busy;
    busy   = 0;
    stalls = 0;
    mem_en = 1'b1; mem_write_en = we; mem_load = ld;
    mem_write_addr = addr; mem_write_data = wd; mem_select = sel;
    #1;
    chk("idle_req", {31'd0, bus_req}, 32'd0);
    for (int c = 0; c < 64; c++) begin
      if (!stall_req) break;
      stalls++;
      chk("stall_err", {31'd0, bus_err}, 32'd0);
      if (bus_req) begin
        chk("busy_addr",  bus_addr, addr & 32'hFFFF_FFFC);
        chk("busy_we",    {31'd0, bus_we}, {31'd0, we});
        chk("busy_sel",   {28'd0, bus_sel}, {28'd0, sel});
        chk("busy_wdata", bus_wdata, wd);
        if (busy == waits) begin bus_ack = 1'b1; bus_rdata = rd; end
        busy++;
      end
      tick();
      bus_ack = 1'b0; bus_rdata = '0;
      #1;
    end
    chk("done_stall", {31'd0, stall_req}, 32'd0);
    chk("done_req",   {31'd0, bus_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
    drop_in(); mem_select = '0; mem_write_addr = '0; mem_write_data = '0;
    #3;
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_req",   {31'd0, bus_req}, 32'd0);
    chk("rst_we",    {31'd0, bus_we}, 32'd0);
    chk("rst_sel",   {28'd0, bus_sel}, 32'd0);
    chk("rst_addr",  bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", read_data_from_mem, 32'd0);
    chk("rst_err",   {31'd0, bus_err}, 32'd0);
    tick(); rst = 1'b0; tick();

    // Load, zero waits.
    xact(1'b0, 1'b1, 32'h0000_0106, 32'h0, 4'hF, 0, 32'hCAFE_F00D, st);
    chk("ld0_stalls", 32'(st), 32'd2);
    chk("ld0_rdata",  read_data_from_mem, 32'hCAFE_F00D);
    drop_in(); tick();

    // Store, three waits: ack lands on what would be the 4th BUSY cycle.
    xact(1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 4'b0011, 3, 32'hFFFF_FFFF, st);
    chk("st3_stalls", 32'(st), 32'd5);
    chk("st3_rdata",  read_data_from_mem, 32'hCAFE_F00D);
    chk("st3_err",    {31'd0, bus_err}, 32'd0);
    drop_in(); tick();

    // Back-to-back loads; second request already present during DONE.
    xact(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'hF, 0, 32'h1111_2222, st);
    chk("b2b_rdata1", read_data_from_mem, 32'h1111_2222);
    mem_write_addr = 32'h0000_020C;
    #1;
    chk("b2b_done_stall", {31'd0, stall_req}, 32'd0);
    tick();
    xact(1'b0, 1'b1, 32'h0000_020C, 32'h0, 4'hF, 0, 32'h3333_4444, st2);
    chk("b2b_stalls1", 32'(st), 32'd2);
    chk("b2b_stalls2", 32'(st2), 32'd2);
    chk("b2b_rdata2",  read_data_from_mem, 32'h3333_4444);
    drop_in(); tick();

    // Enabled but neither load nor store.
    mem_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("noop_stall", {31'd0, stall_req}, 32'd0);
      chk("noop_req",   {31'd0, bus_req}, 32'd0);
      tick();
    end
    drop_in(); tick();

    // Reset during BUSY, then a late ack.
    mem_en = 1'b1; mem_load = 1'b1; mem_write_addr = 32'h0000_0300; mem_select = 4'hF;
    tick();
    chk("rstb_req_busy", {31'd0, bus_req}, 32'd1);
    #2;
    rst = 1'b1; drop_in();
    #1;
    chk("rstb_req",   {31'd0, bus_req}, 32'd0);
    chk("rstb_stall", {31'd0, stall_req}, 32'd0);
    tick();
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h55AA_55AA;
    #1;
    chk("late_stall", {31'd0, stall_req}, 32'd0);
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    chk("late_rdata", read_data_from_mem, 32'd0);
    chk("late_req",   {31'd0, bus_req}, 32'd0);
    tick();

`ifdef MEM_BUS_TIMEOUT_EN
    // Load never acked: abort after 4 BUSY cycles.
    xact(1'b0, 1'b1, 32'h0000_0080, 32'h0, 4'hF, 1000, 32'h0, st);
    chk("to_stalls", 32'(st), 32'd5);
    chk("to_err",    {31'd0, bus_err}, 32'd1);
    chk("to_rdata",  read_data_from_mem, 32'hDEAD_BEEF);
    drop_in(); tick();
    chk("to_err_end", {31'd0, bus_err}, 32'd0);
    chk("to_resume",  {31'd0, stall_req}, 32'd0);
`else
    // Without the watchdog BUSY waits past 4 cycles for the ack.
    xact(1'b0, 1'b1, 32'h0000_0080, 32'h0, 4'hF, 7, 32'h7777_8888, st);
    chk("long_stalls", 32'(st), 32'd9);
    chk("long_err",    {31'd0, bus_err}, 32'd0);
    chk("long_rdata",  read_data_from_mem, 32'h7777_8888);
    drop_in(); tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
